// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported synchronous memory between instruction fetch and
// the load/store stage, returning read data after a fixed latency.
module mem_port_arbiter #(
  parameter int unsigned AWIDTH      = 14,
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned MAX_DSTREAK = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DWIDTH-1:0] if_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DWIDTH-1:0] d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              stall_if
);

  localparam int unsigned CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int unsigned SW = 4;
  localparam logic [CW-1:0] LAST_CNT = CW'(RD_LATENCY - 1);
  localparam logic [SW-1:0] SMAX     = SW'(MAX_DSTREAK);

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_t;

  state_t        state, state_nx;
  logic          owner_d, owner_d_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [SW-1:0] streak, streak_nx;
  logic          resp, issue_ok, grant_if, grant_d;

  // State, owner, latency and fairness registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      cnt     <= '0;
      streak  <= '0;
    end else begin
      state   <= state_nx;
      owner_d <= owner_d_nx;
      cnt     <= cnt_nx;
      streak  <= streak_nx;
    end
  end

  // Arbitration, next state and memory-side outputs
  always_comb begin
    state_nx   = state;
    owner_d_nx = owner_d;
    cnt_nx     = cnt;
    streak_nx  = streak;
    grant_if   = 1'b0;
    grant_d    = 1'b0;

    resp     = (state == RD_WAIT) && (cnt == LAST_CNT);
    // Reset also blocks the combinational grant path while held
    issue_ok = rst_n && ((state == IDLE) || resp);

    if (issue_ok) begin
      if (d_req && (!if_req || (streak != SMAX))) grant_d = 1'b1;
      else if (if_req)                            grant_if = 1'b1;
    end

    if (state == RD_WAIT) begin
      if (resp) state_nx = IDLE;
      else      cnt_nx   = cnt + CW'(1);
    end

    if (grant_if || (grant_d && (d_we == 4'b0000))) begin
      state_nx   = RD_WAIT;
      owner_d_nx = grant_d;
      cnt_nx     = '0;
    end else if (grant_d) begin
      state_nx = IDLE;
    end

    if (!if_req || grant_if)             streak_nx = '0;
    else if (grant_d && (streak != SMAX)) streak_nx = streak + SW'(1);

    if_gnt    = grant_if;
    d_gnt     = grant_d;
    mem_en    = grant_if || grant_d;
    mem_we    = grant_d ? d_we : 4'b0000;
    mem_addr  = grant_d ? d_addr : (grant_if ? if_addr : '0);
    mem_wdata = grant_d ? d_wdata : '0;
    stall_if  = if_req && !grant_if;

    if_rvalid = resp && !owner_d;
    d_rvalid  = resp && owner_d;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked
// against a cycle-level reference model of the sharing rules.
module tb_mem_port_arbiter;

  localparam int unsigned AW    = 14;
  localparam int unsigned DW    = 32;
  localparam int          LAT_A = 1;
  localparam int          MAX_A = 3;
  localparam int          LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: RD_LATENCY=1
  logic          rst_n, if_req, d_req;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [3:0]    d_we, mem_we;
  logic [DW-1:0] d_wdata, mem_wdata, mem_rdata, if_rdata, d_rdata;
  logic          if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, stall_if;

  // instance B: RD_LATENCY=3
  logic          b_rst_n, b_if_req, b_d_req;
  logic [AW-1:0] b_if_addr, b_d_addr, b_mem_addr;
  logic [3:0]    b_d_we, b_mem_we;
  logic [DW-1:0] b_d_wdata, b_mem_wdata, b_mem_rdata, b_if_rdata, b_d_rdata;
  logic          b_if_gnt, b_d_gnt, b_if_rvalid, b_d_rvalid, b_mem_en, b_stall_if;

  mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .RD_LATENCY(LAT_A), .MAX_DSTREAK(MAX_A)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if)
  );

  mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .RD_LATENCY(LAT_B), .MAX_DSTREAK(3)) dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
    .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_gnt(b_d_gnt),
    .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .stall_if(b_stall_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a read issued at cycle n returns at cycle n+LAT_A; a new
  // issue is allowed when nothing is outstanding or the outstanding read returns now.
  int now, due, streak;
  bit due_d, resp, e_ig, e_dg;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    now = 0; due = -1; streak = 0; due_d = 1'b0;
  endtask

  task automatic sample();
    mem_rdata = DW'($urandom());
    @(negedge clk);
    resp = (due == now);
    e_ig = 1'b0;
    e_dg = 1'b0;
    if ((due < 0) || resp) begin
      if (if_req && d_req) begin
        if (streak == MAX_A) e_ig = 1'b1;
        else                 e_dg = 1'b1;
      end else if (if_req) e_ig = 1'b1;
      else if (d_req)      e_dg = 1'b1;
    end
    chk("if_gnt", 64'(if_gnt), 64'(e_ig));
    chk("d_gnt", 64'(d_gnt), 64'(e_dg));
    chk("mem_en", 64'(mem_en), 64'(e_ig | e_dg));
    chk("mem_we", 64'(mem_we), e_dg ? 64'(d_we) : 64'(0));
    chk("mem_wdata", 64'(mem_wdata), e_dg ? 64'(d_wdata) : 64'(0));
    if (e_ig || e_dg) chk("mem_addr", 64'(mem_addr), e_dg ? 64'(d_addr) : 64'(if_addr));
    chk("if_rvalid", 64'(if_rvalid), 64'(resp && !due_d));
    chk("d_rvalid", 64'(d_rvalid), 64'(resp && due_d));
    chk("if_rdata", 64'(if_rdata), (resp && !due_d) ? 64'(mem_rdata) : 64'(0));
    chk("d_rdata", 64'(d_rdata), (resp && due_d) ? 64'(mem_rdata) : 64'(0));
    chk("stall_if", 64'(stall_if), 64'(if_req && !e_ig));
  endtask

  task automatic advance();
    @(posedge clk);
    if (e_dg && if_req)      streak = (streak >= MAX_A) ? MAX_A : streak + 1;
    else if (e_ig || !if_req) streak = 0;
    if (resp) due = -1;
    if (e_ig || (e_dg && (d_we == 4'b0000))) begin
      due   = now + LAT_A;
      due_d = e_dg;
    end
    now++;
    #1;
  endtask

  initial begin
    int exp_seq[8];
    logic [1:0] code;
    exp_seq = '{2, 2, 2, 1, 2, 2, 2, 1};

    rst_n = 1'b0; if_req = 1'b1; if_addr = '0; d_req = 1'b1; d_we = 4'b0000;
    d_addr = '0; d_wdata = '0; mem_rdata = '0;
    b_rst_n = 1'b0; b_if_req = 1'b0; b_if_addr = '0; b_d_req = 1'b0; b_d_we = 4'b0000;
    b_d_addr = '0; b_d_wdata = '0; b_mem_rdata = '0;
    #3;
    chk("rst_if_gnt", 64'(if_gnt), 64'(0));
    chk("rst_d_gnt", 64'(d_gnt), 64'(0));
    chk("rst_mem_en", 64'(mem_en), 64'(0));
    chk("rst_stall", 64'(stall_if), 64'(1));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; b_rst_n = 1'b1; if_req = 1'b0; d_req = 1'b0;
    model_reset();

    // single fetch read
    if_req = 1'b1; if_addr = AW'(14'h010);
    sample();
    chk("t1_gnt", 64'(if_gnt), 64'(1));
    chk("t1_addr", 64'(mem_addr), 64'(14'h010));
    chk("t1_stall", 64'(stall_if), 64'(0));
    advance(); if_req = 1'b0;
    sample();
    chk("t1_rvalid", 64'(if_rvalid), 64'(1));
    chk("t1_rdata", 64'(if_rdata), 64'(mem_rdata));
    advance();

    // simultaneous requests: data first, fetch issues in the response cycle
    d_req = 1'b1; d_we = 4'b0000; d_addr = AW'(14'h020);
    if_req = 1'b1; if_addr = AW'(14'h004);
    sample();
    chk("t2_dgnt", 64'(d_gnt), 64'(1));
    chk("t2_stall", 64'(stall_if), 64'(1));
    advance(); d_req = 1'b0;
    sample();
    chk("t2_drvalid", 64'(d_rvalid), 64'(1));
    chk("t2_ifgnt", 64'(if_gnt), 64'(1));
    advance(); if_req = 1'b0;
    sample();
    chk("t2_ifrvalid", 64'(if_rvalid), 64'(1));
    advance();

    // store completes in grant cycle, fetch follows immediately
    d_req = 1'b1; d_we = 4'b0011; d_addr = AW'(14'h040); d_wdata = 32'hDEADBEEF;
    sample();
    chk("t3_we", 64'(mem_we), 64'(4'b0011));
    chk("t3_wdata", 64'(mem_wdata), 64'(32'hDEADBEEF));
    advance(); d_req = 1'b0; d_we = 4'b0000; if_req = 1'b1; if_addr = AW'(14'h100);
    sample();
    chk("t3_no_drvalid", 64'(d_rvalid), 64'(0));
    chk("t3_ifgnt", 64'(if_gnt), 64'(1));
    advance(); if_req = 1'b0;
    sample(); advance();

    // fairness streak with both requesters held
    d_req = 1'b1; d_we = 4'b0000; if_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d_addr = AW'($urandom()); if_addr = AW'($urandom());
      sample();
      code = {d_gnt, if_gnt};
      chk("t4_order", 64'(code), 64'(exp_seq[i]));
      advance();
    end
    d_req = 1'b0; if_req = 1'b0;
    sample(); advance();

    // idle
    for (int i = 0; i < 10; i++) begin
      sample();
      chk("t5_idle_en", 64'(mem_en), 64'(0));
      advance();
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (!if_req && ($urandom_range(0, 3) != 0)) begin
        if_req = 1'b1; if_addr = AW'($urandom());
      end
      if (!d_req && ($urandom_range(0, 2) != 0)) begin
        d_req = 1'b1; d_addr = AW'($urandom()); d_wdata = DW'($urandom());
        d_we = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      end
      sample();
      advance();
      if (e_ig) if_req = 1'b0;
      if (e_dg) d_req = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;

    // instance B: reset during an in-flight read
    b_if_req = 1'b1; b_if_addr = AW'(14'h010);
    @(negedge clk);
    chk("b_gnt", 64'(b_if_gnt), 64'(1));
    chk("b_en", 64'(b_mem_en), 64'(1));
    @(posedge clk); #1;
    b_if_req = 1'b0;
    #2 b_rst_n = 1'b0;
    #1;
    chk("b_rst_en", 64'(b_mem_en), 64'(0));
    chk("b_rst_we", 64'(b_mem_we), 64'(0));
    chk("b_rst_ifgnt", 64'(b_if_gnt), 64'(0));
    chk("b_rst_rvalid", 64'(b_if_rvalid), 64'(0));
    b_if_req = 1'b1; b_if_addr = AW'(14'h020);
    #1;
    chk("b_rst_stall", 64'(b_stall_if), 64'(1));
    chk("b_rst_gnt_held", 64'(b_if_gnt), 64'(0));
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    b_rst_n = 1'b1;
    b_mem_rdata = 32'h0BADF00D;
    #1;
    chk("b_rel_gnt", 64'(b_if_gnt), 64'(1));
    chk("b_rel_addr", 64'(b_mem_addr), 64'(14'h020));
    chk("b_old_rvalid", 64'(b_if_rvalid), 64'(0));
    @(posedge clk); #1;
    b_if_req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("b_new_rvalid", 64'(b_if_rvalid), 64'(i == 3));
      chk("b_new_rdata", 64'(b_if_rdata), (i == 3) ? 64'(32'h0BADF00D) : 64'(0));
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
